sprite_rom_arbiter: RTL and testbench

- Shares the single sprite ROM port between NUM_REQ requesters, e.g. the per-sprite line fetchers for player, sword, dragon segments and sheep.
- Uses round-robin arbitration, fully pipelined: one ROM read per cycle.
- Each returned 8-bit line goes back to the requester that issued it, with a one-hot valid strobe.
- Sits between the sprite fetch logic and the ROM. It drives the ROM's read_enable, orientation, sprite_ID and line_index, and captures the ROM's registered data output.

---
 rtl/sprite_rom_arbiter.sv | 131 +++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin arbiter sharing the sprite ROM port
//
// Purpose: shares one sprite ROM read port between NUM_REQ line fetchers.
// One grant per cycle, round-robin, with a two-stage tag pipeline that
// routes each registered ROM line back to its requester.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   fetch_enable        0 blocks new grants; reads in flight still complete
//   req                 per-requester request level
//   req_sprite_id       4 bits per requester, requester i at [4i+3:4i]
//   req_orientation     2 bits per requester, requester i at [2i+1:2i]
//   req_line            3 bits per requester, requester i at [3i+2:3i]
//   grant               one-hot one-cycle pulse, request accepted
//   rsp_valid           one-hot one-cycle pulse, rsp_data belongs to requester i
//   rsp_data            returned sprite line, held while rsp_valid is 0
//   rom_read_enable     ROM read strobe
//   rom_sprite_id       ROM sprite ID
//   rom_orientation     ROM orientation
//   rom_line_index      ROM line index
//   rom_data            ROM data, registered in the ROM (1-cycle latency)
module sprite_rom_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fetch_enable,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [4*NUM_REQ-1:0]   req_sprite_id,
   input  logic [2*NUM_REQ-1:0]   req_orientation,
   input  logic [3*NUM_REQ-1:0]   req_line,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [7:0]             rsp_data,
   output logic                   rom_read_enable,
   output logic [3:0]             rom_sprite_id,
   output logic [1:0]             rom_orientation,
   output logic [2:0]             rom_line_index,
   input  logic [7:0]             rom_data
);

   localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   typedef logic [IDW-1:0] idx_t;

   // Unpacked views of the packed per-requester fields so the winner can be
   // selected with an index of exactly the requester-index width.
   logic [3:0] sid_a    [NUM_REQ];
   logic [1:0] orient_a [NUM_REQ];
   logic [2:0] line_a   [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign sid_a[g]    = req_sprite_id[4*g +: 4];
      assign orient_a[g] = req_orientation[2*g +: 2];
      assign line_a[g]   = req_line[3*g +: 3];
   end

   idx_t               ptr;
   idx_t               win_idx;
   idx_t               cand;
   logic               win_found;
   logic               issue;
   logic [NUM_REQ-1:0] eligible;

   logic               tag1_valid;
   idx_t               tag1_idx;
   logic               tag2_valid;
   idx_t               tag2_idx;

   function automatic logic [NUM_REQ-1:0] onehot(input idx_t i);
      logic [NUM_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // A requester granted this cycle is still showing its old request level,
   // so it is masked out; that is what forces at-most-every-other-cycle
   // service for a requester holding req high.
   always_comb begin
      eligible  = req & ~grant;
      win_found = 1'b0;
      win_idx   = ptr;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = idx_t'((int'(ptr) + k) % NUM_REQ);
         if (!win_found && eligible[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      issue = fetch_enable & win_found;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant           <= '0;
         rsp_valid       <= '0;
         rsp_data        <= '0;
         rom_read_enable <= 1'b0;
         rom_sprite_id   <= '0;
         rom_orientation <= '0;
         rom_line_index  <= '0;
         ptr             <= idx_t'(NUM_REQ - 1);
         tag1_valid      <= 1'b0;
         tag1_idx        <= '0;
         tag2_valid      <= 1'b0;
         tag2_idx        <= '0;
      end else begin
         grant           <= issue ? onehot(win_idx) : '0;
         rom_read_enable <= issue;
         tag1_valid      <= issue;
         if (issue) begin
            rom_sprite_id   <= sid_a[win_idx];
            rom_orientation <= orient_a[win_idx];
            rom_line_index  <= line_a[win_idx];
            tag1_idx        <= win_idx;
            ptr             <= win_idx;
         end

         // Stage 2 lines up with the ROM's output register.
         tag2_valid <= tag1_valid;
         tag2_idx   <= tag1_idx;

         rsp_valid <= tag2_valid ? onehot(tag2_idx) : '0;
         if (tag2_valid) begin
            rsp_data <= rom_data;
         end
      end
   end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - directed self-checking bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           fetch_enable;
   logic [N-1:0]   req;
   logic [4*N-1:0] req_sprite_id;
   logic [2*N-1:0] req_orientation;
   logic [3*N-1:0] req_line;
   logic [N-1:0]   grant;
   logic [N-1:0]   rsp_valid;
   logic [7:0]     rsp_data;
   logic           rom_read_enable;
   logic [3:0]     rom_sprite_id;
   logic [1:0]     rom_orientation;
   logic [2:0]     rom_line_index;
   logic [7:0]     rom_q;

   int check_count = 0;
   int err_count   = 0;

   always #5 clk = ~clk;

   sprite_rom_arbiter #(.NUM_REQ(N)) dut (
      .clk             (clk),
      .reset           (rst),
      .fetch_enable    (fetch_enable),
      .req             (req),
      .req_sprite_id   (req_sprite_id),
      .req_orientation (req_orientation),
      .req_line        (req_line),
      .grant           (grant),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .rom_read_enable (rom_read_enable),
      .rom_sprite_id   (rom_sprite_id),
      .rom_orientation (rom_orientation),
      .rom_line_index  (rom_line_index),
      .rom_data        (rom_q)
   );

   // Stub ROM: two real sprite lines, 8'hFF for invalid IDs, and an easy
   // hand-computable {id[2:0], orientation, line} pattern everywhere else.
   function automatic logic [7:0] rom_fn(input logic [3:0] id, input logic [1:0] o,
                                         input logic [2:0] l);
      if (id > 4'd8)                               return 8'hFF;
      if (id == 4'd0 && o == 2'd0 && l == 3'd3)    return 8'b11000000;
      if (id == 4'd1 && o == 2'd2 && l == 3'd1)    return 8'b11000111;
      return {id[2:0], o, l};
   endfunction

   always_ff @(posedge clk) begin
      if (rom_read_enable) rom_q <= rom_fn(rom_sprite_id, rom_orientation, rom_line_index);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act !== exp) begin
         err_count++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] id, input logic [1:0] o,
                          input logic [2:0] l);
      req_sprite_id[4*i +: 4]   = id;
      req_orientation[2*i +: 2] = o;
      req_line[3*i +: 3]        = l;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   logic [7:0] exp_data [4];

   initial begin
      rst             = 1'b1;
      fetch_enable    = 1'b1;
      req             = '0;
      req_sprite_id   = '0;
      req_orientation = '0;
      req_line        = '0;
      rom_q           = 8'h00;
      #3;
      check("rst_grant", grant, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rom_re", rom_read_enable, 0);
      check("rst_rom_fields", {rom_sprite_id, rom_orientation, rom_line_index}, 0);
      check("rst_rsp_data", rsp_data, 0);
      step();
      step();
      rst = 1'b0;

      // Single request: Heart, UP, line 3 on requester 2
      set_req(2, 4'd0, 2'd0, 3'd3);
      req = 4'b0100;
      step();
      check("t1_grant", grant, 4'b0100);
      check("t1_rom_re", rom_read_enable, 1);
      check("t1_rom_fields", {rom_sprite_id, rom_orientation, rom_line_index},
            {4'd0, 2'd0, 3'd3});
      req = '0;
      set_req(2, 4'd7, 2'd1, 3'd0);   // changes after grant must not matter
      step();
      check("t1_grant_drop", grant, 0);
      check("t1_no_rsp_yet", rsp_valid, 0);
      step();
      check("t1_rsp_valid", rsp_valid, 4'b0100);
      check("t1_rsp_data", rsp_data, 8'hC0);
      step();
      check("t1_rsp_pulse", rsp_valid, 0);
      check("t1_rsp_hold", rsp_data, 8'hC0);

      // Simultaneous requests from reset: grants 0,1,2,3
      do_reset();
      set_req(0, 4'd2, 2'd1, 3'd4); exp_data[0] = 8'h4C;
      set_req(1, 4'd1, 2'd2, 3'd1); exp_data[1] = 8'hC7;
      set_req(2, 4'd3, 2'd3, 3'd7); exp_data[2] = 8'h7F;
      set_req(3, 4'd5, 2'd0, 3'd2); exp_data[3] = 8'hA2;
      req = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("t2_grant%0d", k), grant, (k < 4) ? (32'd1 << k) : 32'd0);
         check($sformatf("t2_rsp%0d", k), rsp_valid, (k >= 2) ? (32'd1 << (k - 2)) : 32'd0);
         if (k >= 2) check($sformatf("t2_data%0d", k - 2), rsp_data, exp_data[k - 2]);
         if (k < 4) req[k] = 1'b0;
      end

      // Fairness: requesters 0 and 1 held high
      req = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("t3_grant%0d", k), grant, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      end
      req = '0;
      step(); step(); step();

      // fetch_enable low with everyone requesting; pointer is at 1
      set_req(2, 4'd4, 2'd2, 3'd0);
      fetch_enable = 1'b0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("t4_grant%0d", k), grant, 0);
         check($sformatf("t4_rom_re%0d", k), rom_read_enable, 0);
      end
      fetch_enable = 1'b1;
      step();
      check("t4_first_grant", grant, 4'b0100);
      step();
      check("t5_grant3", grant, 4'b1000);
      req = '0;
      step();
      check("t5_rsp2", rsp_valid, 4'b0100);
      check("t5_rsp2_data", rsp_data, 8'h90);

      // Reset with requester 3's read still in flight
      rst = 1'b1;
      #1;
      check("t5_rst_grant", grant, 0);
      check("t5_rst_rsp_valid", rsp_valid, 0);
      check("t5_rst_rom_re", rom_read_enable, 0);
      check("t5_rst_rom_fields", {rom_sprite_id, rom_orientation, rom_line_index}, 0);
      check("t5_rst_rsp_data", rsp_data, 0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("t5_no_rsp%0d", k), rsp_valid, 0);
      end
      req = 4'b1111;
      step();
      check("t5_first_after_rst", grant, 4'b0001);
      req = '0;
      step(); step(); step();

      // Invalid sprite ID 12, LEFT, line 5 on requester 1
      set_req(1, 4'd12, 2'd3, 3'd5);
      req = 4'b0010;
      step();
      check("t6_grant", grant, 4'b0010);
      check("t6_rom_fields", {rom_sprite_id, rom_orientation, rom_line_index},
            {4'd12, 2'd3, 3'd5});
      req = '0;
      step();
      step();
      check("t6_rsp_valid", rsp_valid, 4'b0010);
      check("t6_rsp_data", rsp_data, 8'hFF);
      step();
      check("t6_rsp_pulse", rsp_valid, 0);
      check("t6_rsp_hold", rsp_data, 8'hFF);

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

endmodule
